// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the parity-protected UART link.
package uart_pkg;

  parameter int unsigned DefaultClksPerBit = 14;
  parameter int unsigned DefaultSamplePt   = 6;

  parameter logic PARITY_EVEN = 1'b0;
  parameter logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line, plus the previous-value register and
// a falling-edge flag. Every flop resets to the idle-high line level.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_s_o,
  output logic rx_prev_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s_o    = sync_q;
  assign rx_prev_o = prev_q;
  assign fall_o    = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 11-bit frames (start, 8 data MSB first, parity, stop), mid-bit sampling,
// byte presented with parity/framing status and a one-cycle completion pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned SAMPLE_PT    = DefaultSamplePt
) (
  input  logic       clk_3125,
  input  logic       rst,
  input  logic       rx,
  input  logic       parity_type,
  output logic [7:0] rx_msg,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_complete
);

  localparam int unsigned     CntW      = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] SampleCnt = CntW'(SAMPLE_PT);

  logic rx_s, rx_prev, rx_fall;

  uart_rx_sync u_sync (
    .clk_i     (clk_3125),
    .rst_i     (rst),
    .rx_i      (rx),
    .rx_s_o    (rx_s),
    .rx_prev_o (rx_prev),
    .fall_o    (rx_fall)
  );

  uart_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] arm_cnt_q, arm_cnt_d;
  logic            armed_q, armed_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic            ptype_q, ptype_d;
  logic [7:0]      msg_q, msg_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            complete_q, complete_d;

  logic at_sample, at_last;
  assign at_sample = (cnt_q == SampleCnt);
  assign at_last   = (cnt_q == LastCnt);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    arm_cnt_d  = arm_cnt_q;
    armed_d    = armed_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    ptype_d    = ptype_q;
    msg_d      = msg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    complete_d = 1'b0;

    // Arm only after a full bit-time of idle line, so a line low out of reset is ignored.
    if (!armed_q) begin
      if (rx_s) begin
        if (arm_cnt_q == LastCnt) begin
          armed_d = 1'b1;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end else begin
        arm_cnt_d = '0;
      end
    end

    if (state_q != StIdle) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (armed_q && rx_fall) begin
          state_d = StStart;
          cnt_d   = CntW'(1);
          ptype_d = parity_type;
        end
      end
      StStart: begin
        if (at_sample && rx_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (at_last) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (at_sample) begin
          shreg_d = {shreg_q[6:0], rx_s};
        end
        if (at_last) begin
          if (idx_q == 3'd7) begin
            state_d = StParity;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (at_sample) begin
          par_d = rx_s;
        end
        if (at_last) begin
          state_d = StStop;
        end
      end
      StStop: begin
        // Finish at mid-stop so a back-to-back start edge is not missed.
        if (at_sample) begin
          msg_d      = shreg_q;
          perr_d     = par_q ^ (^shreg_q) ^ ptype_q;
          ferr_d     = ~rx_s;
          complete_d = 1'b1;
          state_d    = StIdle;
          cnt_d      = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      arm_cnt_q  <= '0;
      armed_q    <= 1'b0;
      idx_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      ptype_q    <= 1'b0;
      msg_q      <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      arm_cnt_q  <= arm_cnt_d;
      armed_q    <= armed_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      ptype_q    <= ptype_d;
      msg_q      <= msg_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      complete_q <= complete_d;
    end
  end

  assign rx_msg        = msg_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_complete   = complete_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames with a scoreboard of expected bytes/flags,
// plus hand-written glitch, framing-error and reset-mid-frame sequences.
module tb_uart_rx;

  localparam int unsigned Cpb = 14;

  logic       clk_3125 = 1'b0;
  logic       rst      = 1'b1;
  logic       rx       = 1'b1;
  logic       parity_type = 1'b0;
  logic [7:0] rx_msg;
  logic       rx_parity_err, rx_frame_err, rx_complete;

  uart_rx dut (
    .clk_3125      (clk_3125),
    .rst           (rst),
    .rx            (rx),
    .parity_type   (parity_type),
    .rx_msg        (rx_msg),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_complete   (rx_complete)
  );

  always #5 clk_3125 = ~clk_3125;

  int cyc = 0;
  always @(posedge clk_3125) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       ptype;
    logic       flip;   // corrupt the parity bit
    logic       stop;
    logic       tog;    // toggle parity_type mid-frame
    int         gap;
  } frame_t;

  typedef struct {
    logic [7:0] msg;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   start_q[$];
  int   pulse_cyc_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_3125);
    #1;
  endtask

  task automatic send_frame(input frame_t f);
    logic [10:0] bits;
    logic        pbit;
    exp_t        e;
    pbit = (f.ptype ? ~^f.data : ^f.data) ^ f.flip;
    bits = {1'b0, f.data, pbit, f.stop};
    parity_type = f.ptype;
    for (int i = 10; i >= 0; i--) begin
      rx = bits[i];
      if (i == 10) begin
        e.msg  = f.data;
        e.perr = f.flip;
        e.ferr = ~f.stop;
        exp_q.push_back(e);
        start_q.push_back(cyc);
      end
      if (i == 9 && f.tog) parity_type = ~f.ptype;
      if (i == 0) parity_type = f.ptype;
      cycles(Cpb);
    end
    if (f.gap > 0) begin
      rx = 1'b1;
      cycles(f.gap);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) cycles(1);
    chk(name, exp_q.size(), 0);
  endtask

  // Scoreboard: each completion pulse pops one expected frame.
  always @(negedge clk_3125) begin
    if (rx_complete) begin
      pulses++;
      pulse_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("spurious_pulse", rx_complete, 0);
      end else begin
        automatic exp_t e = exp_q.pop_front();
        automatic int   s = start_q.pop_front();
        chk("rx_msg", rx_msg, e.msg);
        chk("rx_parity_err", rx_parity_err, e.perr);
        chk("rx_frame_err", rx_frame_err, e.ferr);
        // 2 cycles synchroniser + 1 to the detect edge + 146 to the pulse edge.
        chk("line_to_pulse", cyc - s, 149);
      end
    end
  end

  frame_t vec[5];
  logic [7:0] stream[10];
  frame_t f;
  int p0;

  initial begin
    vec[0] = '{data: 8'hA5, ptype: 1'b0, flip: 1'b0, stop: 1'b1, tog: 1'b0, gap: 1};
    vec[1] = '{data: 8'h07, ptype: 1'b0, flip: 1'b0, stop: 1'b1, tog: 1'b0, gap: 20};
    vec[2] = '{data: 8'h3C, ptype: 1'b1, flip: 1'b0, stop: 1'b1, tog: 1'b0, gap: 20};
    vec[3] = '{data: 8'h3C, ptype: 1'b1, flip: 1'b1, stop: 1'b1, tog: 1'b0, gap: 20};
    vec[4] = '{data: 8'hC3, ptype: 1'b0, flip: 1'b0, stop: 1'b1, tog: 1'b1, gap: 20};
    stream = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'h55};

    cycles(3);
    chk("reset_msg", rx_msg, 8'h00);
    chk("reset_complete", rx_complete, 0);
    rst = 1'b0;
    cycles(1);
    chk("post_reset_perr", rx_parity_err, 0);
    chk("post_reset_ferr", rx_frame_err, 0);
    cycles(20);

    for (int i = 0; i < 5; i++) send_frame(vec[i]);
    drain("table_drain");
    chk("b2b_spacing", pulse_cyc_q[1] - pulse_cyc_q[0], 155);

    // Ten frames streamed with a 1-cycle gap.
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      f = '{data: stream[i], ptype: 1'b0, flip: 1'b0, stop: 1'b1, tog: 1'b0, gap: 1};
      send_frame(f);
    end
    cycles(20);
    drain("stream_drain");
    chk("stream_pulses", pulses - p0, 10);

    // Stop bit low, line stays low: no re-detection until it rises and falls again.
    f = '{data: 8'h81, ptype: 1'b0, flip: 1'b0, stop: 1'b0, tog: 1'b0, gap: 0};
    send_frame(f);
    rx = 1'b0;
    cycles(200);
    drain("ferr_drain");
    p0 = pulses;
    rx = 1'b1;
    cycles(20);
    f = '{data: 8'h66, ptype: 1'b1, flip: 1'b0, stop: 1'b1, tog: 1'b0, gap: 20};
    send_frame(f);
    drain("recover_drain");
    chk("recover_pulses", pulses - p0, 1);

    // Glitch shorter than half a bit.
    p0 = pulses;
    rx = 1'b0;
    cycles(4);
    rx = 1'b1;
    cycles(200);
    chk("glitch_no_pulse", pulses - p0, 0);
    chk("glitch_hold_msg", rx_msg, 8'h66);

    // Reset during data bit 3 of a 0x00 frame.
    p0 = pulses;
    rx = 1'b0;
    cycles(Cpb * 4 + 7);
    rst = 1'b1;
    #1;
    chk("rst_msg", rx_msg, 8'h00);
    chk("rst_perr", rx_parity_err, 0);
    chk("rst_ferr", rx_frame_err, 0);
    cycles(2);
    rst = 1'b0;
    rx  = 1'b1;
    cycles(200);
    chk("rst_no_pulse", pulses - p0, 0);
    f = '{data: 8'h5A, ptype: 1'b0, flip: 1'b0, stop: 1'b1, tog: 1'b0, gap: 20};
    send_frame(f);
    drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the 8-bit, parity-protected UART link driven by `uart_tx`. It runs on the same 3.125 MHz clock at 14 clocks per bit and deserialises 11-bit frames: start 0, data MSB first, parity, stop 1. It presents each byte with parity and framing status and a one-cycle completion pulse. It sits at the far end of the colour-sensor data path, feeding whichever consumer needs the received byte.

## Interface
- `CLKS_PER_BIT`, 14: clock cycles per bit.
- `SAMPLE_PT`, 6: count value within a bit at which the line is sampled (mid-bit).
- `clk_3125`  in  1  system clock, 3.125 MHz, rising-edge.
- `rst`  in  1  reset. Asynchronous, active-high.
- `rx`  in  1  serial line, asynchronous to `clk_3125`, idles high.
- `parity_type`  in  1  0 = even (parity bit = ^data), 1 = odd (parity bit = ~^data).
- `rx_msg`  out  8  last received byte; first data bit on the line lands in bit 7.
- `rx_parity_err`  out  1  parity status of the last frame.
- `rx_frame_err`  out  1  set when the last frame's stop bit was sampled as 0.
- `rx_complete`  out  1  one-cycle pulse when a frame has been received.

## Operation
- Input conditioning: `rx` passes through a 2-flop synchroniser, giving `rx_s`. The previous value is held as `rx_prev`. Both synchroniser flops and `rx_prev` reset to 1.
- Arming: after reset the receiver is disarmed. It arms once `rx_s` has been 1 for `CLKS_PER_BIT` consecutive cycles. It stays armed until the next reset.
- FSM states: IDLE, START, DATA, PARITY, STOP. A bit counter `cnt` runs 0..CLKS_PER_BIT-1. A data index runs 0..7.
- IDLE: when armed and `rx_s`=0 with `rx_prev`=1, on that edge:
  - go to START;
  - set `cnt`=1 (the detect cycle is bit-cycle 0);
  - latch `parity_type` for the whole frame.
- Sampling, all states: the line is sampled when `cnt`==SAMPLE_PT. The state advances when `cnt`==CLKS_PER_BIT-1, with `cnt` wrapping to 0.
- START: if the mid-bit sample is 1, it was a false start; return to IDLE immediately with no pulse and outputs unchanged.
- DATA: each mid-bit sample shifts in as `shreg <= {shreg[6:0], rx_s}`. After 8 bits, go to PARITY.
- PARITY: capture bit `p`.
- STOP: at the mid-bit sample, on the same edge:
  - `rx_msg` <= `shreg`;
  - `rx_parity_err` <= `p ^ (^shreg) ^ parity_type_latched`;
  - `rx_frame_err` <= ~`rx_s`;
  - `rx_complete` <= 1;
  - state <= IDLE.
  Returning at mid-stop lets the receiver accept a back-to-back frame.
- Errored frames still pulse `rx_complete` and still update `rx_msg`.
- A stop bit of 0 followed by a low line: no new start is detected until `rx_s` rises and falls again.
- `parity_type` changes mid-frame are ignored.

## Timing
- Reset values: `rx_msg`=0x00, `rx_parity_err`=0, `rx_frame_err`=0, `rx_complete`=0. The FSM goes to IDLE and is disarmed.
- Reset mid-frame aborts the frame; no pulse is produced.
- Line-to-detect latency: a falling edge on `rx` is seen as the start-detect edge 2 cycles later (synchroniser).
- Detect-to-pulse: `rx_complete` goes high at detect edge + 10·CLKS_PER_BIT + SAMPLE_PT = 146 cycles. It is high for exactly 1 cycle.
- Outputs other than `rx_complete` change only on that edge and hold until the next completion or reset.
- Throughput: accepts `uart_tx` frames of 154 cycles separated by a 1-cycle gap, indefinitely, with no lost frames.
- Tolerance: the sample point must stay within a bit for ±2 cycles of accumulated offset per frame.

## Structure
- `uart_pkg` holds:
  - `CLKS_PER_BIT` and `SAMPLE_PT` defaults;
  - the FSM state encoding (shared with `uart_tx` where it overlaps);
  - constants `PARITY_EVEN`=0 and `PARITY_ODD`=1.
- Sub-module `uart_rx_sync` contains the 2-flop synchroniser, the `rx_prev` register and the falling-edge output, with reset to 1.
- The FSM, counters, shift register and output registers live in `uart_rx`.

## Test plan
- Even parity, send 0xA5 (p=0) then 0x07 (p=1), frames back-to-back with a 1-cycle gap -> two pulses 155 cycles apart; `rx_msg`=0xA5 then 0x07; both error flags 0.
- Odd parity, send 0x3C with p=1 -> `rx_msg`=0x3C, `rx_parity_err`=0; the same frame with p=0 -> `rx_parity_err`=1 and `rx_msg`=0x3C.
- Frame 0x81 with the stop bit forced to 0 -> pulse; `rx_msg`=0x81, `rx_frame_err`=1. No further frame is detected until the line returns high and then falls again.
- Glitch: `rx` low for 4 cycles, then high -> no `rx_complete`; `rx_msg` keeps its previous value.
- `rst` pulsed during data bit 3 of a 0x00 frame -> outputs 0 immediately; that frame yields no pulse. The next clean frame 0x5A is received correctly.
- Ten frames streamed from `uart_tx` (data.txt payloads) -> ten pulses, each `rx_msg` equal to the transmitted `data`, zero errors.
